// File: rtl/pixel_stream_feeder.sv
//------------------------------------------------------------------------------
// pixel_stream_feeder
//
// Upstream stage of the colour-transform block. Accepts a raw RGB pixel stream
// under valid/ready, buffers it in a small synchronous FIFO, tags each pixel
// with raster coordinates and issues it as a one-cycle valid pulse. Pulses are
// never closer than PACE cycles apart, which matches the transform's
// WAIT->COMPUTE->SEND cadence. Single clock domain (clk_25).
//
// Build option:
//   TEST_PATTERN_EN  adds input test_mode. While test_mode=1 the FIFO is
//                    frozen (no pops, in_ready=0) and eight vertical colour
//                    bars are generated at the normal cadence instead.
//
// Parameters:
//   H_ACTIVE  pixels per line (x wraps after H_ACTIVE-1)
//   V_ACTIVE  lines per frame (y wraps after V_ACTIVE-1)
//   DEPTH     FIFO entries, power of 2, >= 2
//   PACE      minimum cycles between valid pulses, >= 1
//
// Ports:
//   clk_25        in   pixel clock
//   reset         in   asynchronous active-high reset
//   in_valid      in   source pixel present
//   in_ready      out  FIFO can accept (not full, not in test mode)
//   in_sof        in   pixel is first of frame
//   in_red/green/blue in  8-bit source colour
//   test_mode     in   colour-bar generator select (TEST_PATTERN_EN only)
//   valid         out  one-cycle pulse: outputs hold a new pixel
//   x_o, y_o      out  10-bit coordinates of issued pixel
//   red_o/green_o/blue_o out  issued colour
//   frame_done    out  pulses with valid on pixel (H_ACTIVE-1, V_ACTIVE-1)
//------------------------------------------------------------------------------
module pixel_stream_feeder #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned DEPTH    = 8,
    parameter int unsigned PACE     = 3
) (
    input  logic       clk_25,
    input  logic       reset,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic       in_sof,
    input  logic [7:0] in_red,
    input  logic [7:0] in_green,
    input  logic [7:0] in_blue,
`ifdef TEST_PATTERN_EN
    input  logic       test_mode,
`endif
    output logic       valid,
    output logic [9:0] x_o,
    output logic [9:0] y_o,
    output logic [7:0] red_o,
    output logic [7:0] green_o,
    output logic [7:0] blue_o,
    output logic       frame_done
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = (PACE > 1) ? $clog2(PACE) : 1;

    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);
    localparam logic [AW:0] ONE_CNT  = (AW + 1)'(1);
    localparam logic [9:0]  X_LAST   = 10'(H_ACTIVE - 1);
    localparam logic [9:0]  Y_LAST   = 10'(V_ACTIVE - 1);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_HOLD = 1'b1
    } state_t;

    // FIFO storage and bookkeeping
    logic [24:0]   mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW:0]   count_q;
    logic [AW:0]   count_d;
    logic          full;
    logic          empty;
    logic          push;
    logic          pop;
    logic          tm;

    // Issue FSM and registered outputs
    state_t        state_q;
    logic [PW-1:0] pace_q;
    logic [9:0]    xc_q;          // raster position the next issued pixel takes
    logic [9:0]    yc_q;
    logic          valid_q;
    logic          frame_done_q;
    logic [9:0]    x_q;
    logic [9:0]    y_q;
    logic [7:0]    red_q;
    logic [7:0]    green_q;
    logic [7:0]    blue_q;

    // Issue-slot datapath
    logic          issue;
    logic [24:0]   head;
    logic          sof_d;
    logic [7:0]    red_d;
    logic [7:0]    green_d;
    logic [7:0]    blue_d;
    logic [9:0]    x_d;
    logic [9:0]    y_d;
    logic [9:0]    xc_d;
    logic [9:0]    yc_d;
    logic          frame_done_d;

`ifdef TEST_PATTERN_EN
    assign tm = test_mode;

    // Bar index 0..7 across the active line.
    function automatic logic [2:0] bar_of(input logic [9:0] x);
        logic [31:0] scaled;
        scaled = (32'(x) * 32'd8) / 32'(H_ACTIVE);
        return scaled[2:0];
    endfunction
`else
    assign tm = 1'b0;
`endif

    //--------------------------------------------------------------------------
    // FIFO
    //--------------------------------------------------------------------------
    assign full     = (count_q == FULL_CNT);
    assign empty    = (count_q == '0);
    assign in_ready = !full && !tm;
    assign push     = in_valid && in_ready;
    assign head     = mem_q[rd_ptr_q];

    always_comb begin
        count_d = count_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + ONE_CNT;
            2'b01:   count_d = count_q - ONE_CNT;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_25) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {in_sof, in_red, in_green, in_blue};
        end
    end

    always_ff @(posedge clk_25 or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            // DEPTH is a power of two, so the pointers wrap naturally.
            if (push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            count_q <= count_d;
        end
    end

    //--------------------------------------------------------------------------
    // Issue-slot datapath: what would be issued if this cycle is an issue slot
    //--------------------------------------------------------------------------
    // An issue slot is any IDLE cycle with something to send: a queued pixel,
    // or a generated bar pixel in test mode.
    assign issue = (state_q == S_IDLE) && (tm || !empty);
    assign pop   = issue && !tm;

    always_comb begin
        sof_d   = head[24];
        red_d   = head[23:16];
        green_d = head[15:8];
        blue_d  = head[7:0];
        if (tm) begin
            sof_d = 1'b0;
        end

        // sof realigns the raster: this pixel is (0,0) whatever the counter says.
        x_d = sof_d ? '0 : xc_q;
        y_d = sof_d ? '0 : yc_q;

`ifdef TEST_PATTERN_EN
        if (tm) begin
            red_d   = {8{bar_of(x_d)[2]}};
            green_d = {8{bar_of(x_d)[1]}};
            blue_d  = {8{bar_of(x_d)[0]}};
        end
`endif

        frame_done_d = 1'b0;
        if (x_d == X_LAST) begin
            xc_d = '0;
            if (y_d == Y_LAST) begin
                yc_d         = '0;
                frame_done_d = 1'b1;
            end else begin
                yc_d = y_d + 10'd1;
            end
        end else begin
            xc_d = x_d + 10'd1;
            yc_d = y_d;
        end
    end

    //--------------------------------------------------------------------------
    // Issue FSM with registered outputs
    //--------------------------------------------------------------------------
    always_ff @(posedge clk_25 or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            pace_q       <= '0;
            xc_q         <= '0;
            yc_q         <= '0;
            valid_q      <= 1'b0;
            frame_done_q <= 1'b0;
            x_q          <= '0;
            y_q          <= '0;
            red_q        <= '0;
            green_q      <= '0;
            blue_q       <= '0;
        end else begin
            valid_q      <= 1'b0;
            frame_done_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (issue) begin
                        valid_q      <= 1'b1;
                        frame_done_q <= frame_done_d;
                        x_q          <= x_d;
                        y_q          <= y_d;
                        red_q        <= red_d;
                        green_q      <= green_d;
                        blue_q       <= blue_d;
                        xc_q         <= xc_d;
                        yc_q         <= yc_d;
                        if (PACE > 1) begin
                            pace_q  <= PW'(PACE - 1);
                            state_q <= S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    // Leaving on the last count makes the next issue land exactly
                    // PACE cycles after the previous one.
                    if (pace_q <= PW'(1)) begin
                        pace_q  <= '0;
                        state_q <= S_IDLE;
                    end else begin
                        pace_q <= pace_q - PW'(1);
                    end
                end
            endcase
        end
    end

    assign valid      = valid_q;
    assign frame_done = frame_done_q;
    assign x_o        = x_q;
    assign y_o        = y_q;
    assign red_o      = red_q;
    assign green_o    = green_q;
    assign blue_o     = blue_q;

endmodule

// File: tb/tb_pixel_stream_feeder.sv
module tb_pixel_stream_feeder;

    localparam int unsigned H = 640;
    localparam int unsigned V = 4;
    localparam int unsigned D = 8;
    localparam int unsigned P = 3;

    logic       clk_25    = 1'b0;
    logic       reset     = 1'b1;
    logic       in_valid  = 1'b0;
    logic       in_sof    = 1'b0;
    logic [7:0] in_red    = '0;
    logic [7:0] in_green  = '0;
    logic [7:0] in_blue   = '0;
    logic       test_mode = 1'b0;
    logic       in_ready;
    logic       valid;
    logic       frame_done;
    logic [9:0] x_o;
    logic [9:0] y_o;
    logic [7:0] red_o;
    logic [7:0] green_o;
    logic [7:0] blue_o;

    pixel_stream_feeder #(
        .H_ACTIVE(H),
        .V_ACTIVE(V),
        .DEPTH   (D),
        .PACE    (P)
    ) dut (
        .clk_25    (clk_25),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sof    (in_sof),
        .in_red    (in_red),
        .in_green  (in_green),
        .in_blue   (in_blue),
`ifdef TEST_PATTERN_EN
        .test_mode (test_mode),
`endif
        .valid     (valid),
        .x_o       (x_o),
        .y_o       (y_o),
        .red_o     (red_o),
        .green_o   (green_o),
        .blue_o    (blue_o),
        .frame_done(frame_done)
    );

    always #5 clk_25 = ~clk_25;

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    //--------------------------------------------------------------------------
    // Reference model: pixels leave in arrival order; issue happens on the
    // first edge where something is queued and PACE edges have passed since
    // the last issue; coordinates come from a linear index into the frame.
    //--------------------------------------------------------------------------
    typedef struct {
        longint     cyc;
        logic [9:0] x;
        logic [9:0] y;
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
        logic       fd;
    } obs_t;

    typedef struct {
        logic       sof;
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
        longint     cyc;
        logic [9:0] x;
        logic [9:0] y;
    } vec_t;

    int unsigned total = 0;
    int unsigned bad   = 0;
    logic [24:0] fifo_m [$];
    obs_t        log_q [$];
    vec_t        vt [5];
    longint      edge_n = 0;
    longint      last_issue = 0;
    int unsigned idx_m = 0;
    logic [9:0]  ex_x = '0;
    logic [9:0]  ex_y = '0;
    logic [7:0]  ex_r = '0;
    logic [7:0]  ex_g = '0;
    logic [7:0]  ex_b = '0;
    bit          stall_seen = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h (edge %0d)", nm, act, exp, edge_n);
        end
    endtask

    function automatic logic [23:0] bar_rgb(input logic [9:0] x);
        int unsigned bar;
        bar = x;
        bar = (bar * 8) / H;
        return {(bar >= 4) ? 8'hFF : 8'h00,
                (((bar / 2) % 2) == 1) ? 8'hFF : 8'h00,
                ((bar % 2) == 1) ? 8'hFF : 8'h00};
    endfunction

    task automatic model_clear();
        fifo_m.delete();
        idx_m      = 0;
        ex_x       = '0;
        ex_y       = '0;
        ex_r       = '0;
        ex_g       = '0;
        ex_b       = '0;
        last_issue = edge_n - longint'(P);
    endtask

    // One clock: check ready, predict, clock, check all outputs.
    task automatic step(output bit acc);
        int unsigned occ;
        bit          issue;
        bit          tm;
        bit          sof;
        bit          fd;
        logic [24:0] ent;
        logic [24:0] inword;
        logic [23:0] bars;
        obs_t        o;
        #1;
        tm  = (test_mode === 1'b1);
        occ = fifo_m.size();
        chk("in_ready", in_ready, (!tm && occ < D));
        acc    = in_valid && !tm && (occ < D);
        issue  = (tm || occ > 0) && (edge_n - last_issue >= longint'(P));
        inword = {in_sof, in_red, in_green, in_blue};
        fd     = 1'b0;
        if (issue) begin
            ent = '0;
            if (tm) sof = 1'b0;
            else begin
                ent = fifo_m.pop_front();
                sof = ent[24];
            end
            if (sof) idx_m = 0;
            ex_x = 10'(idx_m % H);
            ex_y = 10'((idx_m / H) % V);
            fd   = (idx_m == H * V - 1);
            idx_m = (idx_m + 1) % (H * V);
            if (tm) begin
                bars = bar_rgb(ex_x);
                {ex_r, ex_g, ex_b} = bars;
            end else begin
                {ex_r, ex_g, ex_b} = ent[23:0];
            end
            last_issue = edge_n;
        end
        @(posedge clk_25);
        if (acc) fifo_m.push_back(inword);
        edge_n++;
        @(negedge clk_25);
        chk("valid", valid, issue);
        chk("frame_done", frame_done, fd);
        chk("x_o", x_o, ex_x);
        chk("y_o", y_o, ex_y);
        chk("red_o", red_o, ex_r);
        chk("green_o", green_o, ex_g);
        chk("blue_o", blue_o, ex_b);
        if (valid === 1'b1) begin
            o = '{edge_n - 1, x_o, y_o, red_o, green_o, blue_o, frame_done};
            log_q.push_back(o);
        end
        if (in_ready === 1'b0) stall_seen = 1'b1;
    endtask

    task automatic push_px(input bit sof, input logic [7:0] r, input logic [7:0] g,
                           input logic [7:0] b);
        bit          acc;
        int unsigned n;
        in_valid = 1'b1;
        in_sof   = sof;
        in_red   = r;
        in_green = g;
        in_blue  = b;
        acc = 1'b0;
        n   = 0;
        while (!acc && n < 64) begin
            step(acc);
            n++;
        end
        chk("push_accepted", acc, 1);
    endtask

    task automatic drain();
        bit          acc;
        int unsigned n;
        in_valid = 1'b0;
        in_sof   = 1'b0;
        n = 0;
        while ((fifo_m.size() > 0 || edge_n - last_issue < longint'(P)) && n < 200) begin
            step(acc);
            n++;
        end
        if (n >= 200) begin
            total++;
            bad++;
            $display("FAIL drain: queue still %0d after %0d cycles", fifo_m.size(), n);
        end
    endtask

    task automatic apply_reset();
        in_valid = 1'b0;
        in_sof   = 1'b0;
        reset    = 1'b1;
        #1;
        chk("rst_async_valid", valid, 0);
        chk("rst_async_x", x_o, 0);
        chk("rst_async_ready", in_ready, 1);
        @(posedge clk_25);
        edge_n++;
        @(negedge clk_25);
        chk("rst_valid", valid, 0);
        chk("rst_ready", in_ready, 1);
        chk("rst_x", x_o, 0);
        chk("rst_y", y_o, 0);
        chk("rst_rgb", {red_o, green_o, blue_o}, 0);
        chk("rst_fd", frame_done, 0);
        reset = 1'b0;
        model_clear();
    endtask

    task automatic chk_log(input string nm, input int unsigned i, input logic [9:0] ex,
                           input logic [9:0] ey, input logic efd);
        if (i >= log_q.size()) begin
            chk({nm, "_present"}, log_q.size(), i + 1);
        end else begin
            chk({nm, "_x"}, log_q[i].x, ex);
            chk({nm, "_y"}, log_q[i].y, ey);
            chk({nm, "_fd"}, log_q[i].fd, efd);
        end
    endtask

    function automatic int unsigned fd_count();
        int unsigned c;
        c = 0;
        foreach (log_q[i]) if (log_q[i].fd) c++;
        return c;
    endfunction

    initial begin
        bit     acc;
        longint t0;

        vt[0] = '{1'b1, 8'h11, 8'h21, 8'h31, 1,  10'd0, 10'd0};
        vt[1] = '{1'b0, 8'h12, 8'h22, 8'h32, 4,  10'd1, 10'd0};
        vt[2] = '{1'b0, 8'h13, 8'h23, 8'h33, 7,  10'd2, 10'd0};
        vt[3] = '{1'b0, 8'h14, 8'h24, 8'h34, 10, 10'd3, 10'd0};
        vt[4] = '{1'b0, 8'h15, 8'h25, 8'h35, 13, 10'd4, 10'd0};

        // Power-on reset state
        repeat (2) @(posedge clk_25);
        @(negedge clk_25);
        chk("por_valid", valid, 0);
        chk("por_ready", in_ready, 1);
        chk("por_xy", {x_o, y_o}, 0);
        chk("por_rgb", {red_o, green_o, blue_o}, 0);
        chk("por_fd", frame_done, 0);
        reset = 1'b0;
        model_clear();

        // Reset mid-stream with entries queued
        push_px(1'b1, 8'h01, 8'h02, 8'h03);
        for (int i = 0; i < 4; i++) push_px(1'b0, 8'(i), 8'h40, 8'h50);
        apply_reset();
        repeat (6) step(acc);
        log_q.delete();
        push_px(1'b1, 8'hAA, 8'hBB, 8'hCC);
        drain();
        chk("t1_count", log_q.size(), 1);
        chk_log("t1_first", 0, 10'd0, 10'd0, 1'b0);
        if (log_q.size() > 0) chk("t1_rgb", {log_q[0].r, log_q[0].g, log_q[0].b}, 24'hAABBCC);

        // Table: five back-to-back pixels, cadence and order
        log_q.delete();
        t0 = edge_n;
        for (int i = 0; i < 5; i++) push_px(vt[i].sof, vt[i].r, vt[i].g, vt[i].b);
        drain();
        chk("t2_count", log_q.size(), 5);
        for (int i = 0; i < 5; i++) begin
            if (i < log_q.size()) begin
                chk("t2_cycle", log_q[i].cyc - t0, vt[i].cyc);
                chk("t2_xy", {log_q[i].x, log_q[i].y}, {vt[i].x, vt[i].y});
                chk("t2_rgb", {log_q[i].r, log_q[i].g, log_q[i].b}, {vt[i].r, vt[i].g, vt[i].b});
            end
        end

        // Fill past DEPTH: source stalls, nothing lost
        log_q.delete();
        stall_seen = 1'b0;
        for (int i = 0; i < 20; i++) push_px(i == 0, 8'(i), ~8'(i), 8'(i + 64));
        drain();
        chk("t3_stall_seen", stall_seen, 1);
        chk("t3_count", log_q.size(), 20);
        for (int i = 0; i < 20; i++) begin
            if (i < log_q.size()) begin
                chk("t3_order", {log_q[i].r, log_q[i].g, log_q[i].b},
                    {8'(i), ~8'(i), 8'(i + 64)});
                chk("t3_x", log_q[i].x, 10'(i));
            end
        end

        // Whole frame plus one
        log_q.delete();
        push_px(1'b1, 8'h00, 8'h00, 8'h00);
        for (int i = 1; i <= H * V; i++)
            push_px(1'b0, 8'($urandom()), 8'($urandom()), 8'($urandom()));
        drain();
        chk_log("t4_line0_end", H - 1, 10'd639, 10'd0, 1'b0);
        chk_log("t4_line1_start", H, 10'd0, 10'd1, 1'b0);
        chk_log("t4_frame_end", H * V - 1, 10'd639, 10'(V - 1), 1'b1);
        chk_log("t4_wrap", H * V, 10'd0, 10'd0, 1'b0);
        chk("t4_fd_count", fd_count(), 1);

        // sof mid-frame at pixel 100 of line 2
        log_q.delete();
        push_px(1'b1, 8'h01, 8'h01, 8'h01);
        for (int i = 1; i < 2 * H + 100; i++) push_px(1'b0, 8'h02, 8'h02, 8'h02);
        push_px(1'b1, 8'h5A, 8'h5B, 8'h5C);
        for (int i = 0; i < 50; i++) push_px(1'b0, 8'h03, 8'h03, 8'h03);
        drain();
        chk_log("t5_before", 2 * H + 99, 10'd99, 10'd2, 1'b0);
        chk_log("t5_sof", 2 * H + 100, 10'd0, 10'd0, 1'b0);
        chk_log("t5_after", 2 * H + 101, 10'd1, 10'd0, 1'b0);
        chk("t5_fd_count", fd_count(), 0);

        // Randomised stream checked by the model every cycle
        acc = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            if (!in_valid || acc) begin
                in_valid = ($urandom_range(0, 3) != 0);
                in_sof   = ($urandom_range(0, 99) == 0);
                in_red   = 8'($urandom());
                in_green = 8'($urandom());
                in_blue  = 8'($urandom());
            end
            step(acc);
        end
        drain();

`ifdef TEST_PATTERN_EN
        // Colour bars in test mode
        apply_reset();
        log_q.delete();
        test_mode = 1'b1;
        in_valid  = 1'b1;
        in_red    = 8'h77;
        repeat (H * P + 6) step(acc);
        test_mode = 1'b0;
        drain();
        chk_log("t6_x0", 0, 10'd0, 10'd0, 1'b0);
        chk_log("t6_x80", 80, 10'd80, 10'd0, 1'b0);
        chk_log("t6_x639", 639, 10'd639, 10'd0, 1'b0);
        if (log_q.size() > 639) begin
            chk("t6_rgb0", {log_q[0].r, log_q[0].g, log_q[0].b}, 24'h000000);
            chk("t6_rgb80", {log_q[80].r, log_q[80].g, log_q[80].b}, 24'h0000FF);
            chk("t6_rgb639", {log_q[639].r, log_q[639].g, log_q[639].b}, 24'hFFFFFF);
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
